// File: rtl/bp_io_host_responder.sv
// bp_io_host_responder: host MMIO responder for putchar, per-core finish flags and a 64-bit cycle counter.
// Ports: clk_i, reset_n_i (sync, active-low); io_cmd_* command in (v/ready); io_resp_* response out (v/yumi),
// echoing w/addr/size with size-masked read data; char_v_o/char_o putchar pulse; program_finish_o/program_fail_o
// sticky per-core flags; decode_err_o sticky unmapped-access flag.
// Optional: define BP_IO_HOST_PRINT_EN for simulation console output (chars, finish results, decode errors).
module bp_io_host_responder #(
  parameter int paddr_width_p = 40,
  parameter int data_width_p = 64,
  parameter int num_core_p = 1
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     io_cmd_v_i,
  output logic                     io_cmd_ready_o,
  input  logic                     io_cmd_w_i,
  input  logic [paddr_width_p-1:0] io_cmd_addr_i,
  input  logic [1:0]               io_cmd_size_i,
  input  logic [data_width_p-1:0]  io_cmd_data_i,
  output logic                     io_resp_v_o,
  input  logic                     io_resp_yumi_i,
  output logic                     io_resp_w_o,
  output logic [paddr_width_p-1:0] io_resp_addr_o,
  output logic [1:0]               io_resp_size_o,
  output logic [data_width_p-1:0]  io_resp_data_o,
  output logic                     char_v_o,
  output logic [7:0]               char_o,
  output logic [num_core_p-1:0]    program_finish_o,
  output logic [num_core_p-1:0]    program_fail_o,
  output logic                     decode_err_o
);
  localparam logic [paddr_width_p-1:0] put_addr = paddr_width_p'(64'h10_1000);
  localparam logic [paddr_width_p-1:0] fin_base = paddr_width_p'(64'h10_2000);
  localparam logic [paddr_width_p-1:0] cnt_addr = paddr_width_p'(64'h10_3000);
  typedef enum logic {e_idle, e_resp} state_e;
  state_e state_r, state_n;
  logic accept;
  logic put_hit, cnt_hit, fin_hit;
  logic [num_core_p-1:0] fin_sel;
  logic [1:0] fin_rd;
  logic [data_width_p-1:0] mask, rd_data;
  logic [63:0] cnt_r;
  always_comb begin
    io_cmd_ready_o = reset_n_i & (state_r == e_idle);
    io_resp_v_o = state_r == e_resp;
    accept = io_cmd_v_i & io_cmd_ready_o;
    state_n = accept ? e_resp : (io_resp_v_o & io_resp_yumi_i) ? e_idle : state_r;
  end
  always_comb begin
    fin_sel = '0;
    fin_rd = '0;
    for (int i = 0; i < num_core_p; i++)
      if (io_cmd_addr_i == fin_base + paddr_width_p'(8 * i)) begin
        fin_sel[i] = 1'b1;
        fin_rd = {program_fail_o[i], program_finish_o[i]};
      end
  end
  // size 3 shifts by the full width, which yields zero and hence an all-ones mask
  assign mask = ~({data_width_p{1'b1}} << (32'd8 << io_cmd_size_i));
  assign put_hit = io_cmd_addr_i == put_addr;
  assign cnt_hit = io_cmd_addr_i == cnt_addr;
  assign fin_hit = |fin_sel;
  assign rd_data = fin_hit ? data_width_p'(fin_rd) : cnt_hit ? data_width_p'(cnt_r) : '0;
  always_ff @(posedge clk_i)
    if (!reset_n_i) cnt_r <= '0;
    else cnt_r <= (accept & io_cmd_w_i & cnt_hit) ? 64'(io_cmd_data_i & mask) : cnt_r + 64'd1;
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      io_resp_w_o <= 1'b0;
      io_resp_addr_o <= '0;
      io_resp_size_o <= '0;
      io_resp_data_o <= '0;
      char_v_o <= 1'b0;
      char_o <= '0;
      program_finish_o <= '0;
      program_fail_o <= '0;
      decode_err_o <= 1'b0;
    end else begin
      state_r <= state_n;
      char_v_o <= accept & io_cmd_w_i & put_hit;
      if (accept) begin
        io_resp_w_o <= io_cmd_w_i;
        io_resp_addr_o <= io_cmd_addr_i;
        io_resp_size_o <= io_cmd_size_i;
        io_resp_data_o <= io_cmd_w_i ? '0 : rd_data & mask;
        if (io_cmd_w_i & put_hit) char_o <= io_cmd_data_i[7:0];
        for (int i = 0; i < num_core_p; i++)
          if (io_cmd_w_i & fin_sel[i]) begin
            program_finish_o[i] <= 1'b1;
            program_fail_o[i] <= io_cmd_data_i[0];
          end
        if (!(put_hit | cnt_hit | fin_hit)) decode_err_o <= 1'b1;
      end
    end
  end
`ifdef BP_IO_HOST_PRINT_EN
  always @(posedge clk_i) begin
    if (reset_n_i & char_v_o) $write("%c", char_o);
    for (int i = 0; i < num_core_p; i++)
      if (accept & io_cmd_w_i & fin_sel[i]) $display("[bp_io_host] core %0d %s", i, io_cmd_data_i[0] ? "FAIL" : "PASS");
    if (accept & !(put_hit | cnt_hit | fin_hit)) $display("[bp_io_host] decode error at address %h", io_cmd_addr_i);
  end
`else
`endif
endmodule

// File: tb/tb_bp_io_host_responder.sv
// tb_bp_io_host_responder: directed table-driven bench for bp_io_host_responder.
module tb_bp_io_host_responder;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cmd_v = 1'b0, cmd_w = 1'b0, cmd_ready;
  logic [39:0] cmd_addr = '0;
  logic [1:0] cmd_size = '0;
  logic [63:0] cmd_data = '0;
  logic resp_v, yumi = 1'b0, resp_w;
  logic [39:0] resp_addr;
  logic [1:0] resp_size;
  logic [63:0] resp_data;
  logic char_v;
  logic [7:0] char_c;
  logic [0:0] fin, fail;
  logic derr;
  int total = 0, bad = 0;
  int nchar;
  typedef struct {
    int gap;
    logic w;
    logic [39:0] addr;
    logic [1:0] size;
    logic [63:0] data;
    logic [63:0] exp_data;
    logic exp_cv;
    logic [7:0] exp_char;
    logic exp_fin;
    logic exp_fail;
    logic exp_derr;
  } vec_t;
  vec_t tv[18];
  always #5 clk = ~clk;
  bp_io_host_responder #(.paddr_width_p(40), .data_width_p(64), .num_core_p(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .io_cmd_v_i(cmd_v), .io_cmd_ready_o(cmd_ready), .io_cmd_w_i(cmd_w),
    .io_cmd_addr_i(cmd_addr), .io_cmd_size_i(cmd_size), .io_cmd_data_i(cmd_data),
    .io_resp_v_o(resp_v), .io_resp_yumi_i(yumi), .io_resp_w_o(resp_w),
    .io_resp_addr_o(resp_addr), .io_resp_size_o(resp_size), .io_resp_data_o(resp_data),
    .char_v_o(char_v), .char_o(char_c),
    .program_finish_o(fin), .program_fail_o(fail), .decode_err_o(derr)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input int gap, input logic w, input logic [39:0] a, input logic [1:0] s,
                              input logic [63:0] d, input logic [63:0] e, input logic cv, input logic [7:0] c,
                              input logic f, input logic fl, input logic de);
    vec_t v;
    v.gap = gap; v.w = w; v.addr = a; v.size = s; v.data = d; v.exp_data = e;
    v.exp_cv = cv; v.exp_char = c; v.exp_fin = f; v.exp_fail = fl; v.exp_derr = de;
    return v;
  endfunction
  // starts and ends at a falling edge; accept edge, then yumi on the following edge
  task automatic do_cmd(input vec_t v, input int k);
    repeat (v.gap) @(negedge clk);
    chk($sformatf("ready[%0d]", k), 64'(cmd_ready), 64'd1);
    cmd_v = 1'b1; cmd_w = v.w; cmd_addr = v.addr; cmd_size = v.size; cmd_data = v.data;
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;
    chk($sformatf("resp_v[%0d]", k), 64'(resp_v), 64'd1);
    chk($sformatf("resp_w[%0d]", k), 64'(resp_w), 64'(v.w));
    chk($sformatf("resp_addr[%0d]", k), 64'(resp_addr), 64'(v.addr));
    chk($sformatf("resp_size[%0d]", k), 64'(resp_size), 64'(v.size));
    chk($sformatf("resp_data[%0d]", k), resp_data, v.exp_data);
    chk($sformatf("char_v[%0d]", k), 64'(char_v), 64'(v.exp_cv));
    if (v.exp_cv) chk($sformatf("char[%0d]", k), 64'(char_c), 64'(v.exp_char));
    chk($sformatf("busy_ready[%0d]", k), 64'(cmd_ready), 64'd0);
    chk($sformatf("finish[%0d]", k), 64'(fin), 64'(v.exp_fin));
    chk($sformatf("fail[%0d]", k), 64'(fail), 64'(v.exp_fail));
    chk($sformatf("decode_err[%0d]", k), 64'(derr), 64'(v.exp_derr));
    yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi = 1'b0;
    chk($sformatf("resp_done[%0d]", k), 64'(resp_v), 64'd0);
    chk($sformatf("char_pulse_end[%0d]", k), 64'(char_v), 64'd0);
  endtask
  initial begin
    tv[0]  = mk(3, 1'b0, 40'h10_3000, 2'd3, 64'h0, 64'd3, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[1]  = mk(0, 1'b1, 40'h10_1000, 2'd0, 64'h41, 64'h0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    tv[2]  = mk(0, 1'b1, 40'h10_3000, 2'd3, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[3]  = mk(1, 1'b0, 40'h10_3000, 2'd3, 64'h0, 64'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[4]  = mk(0, 1'b1, 40'h10_3000, 2'd3, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[5]  = mk(0, 1'b0, 40'h10_3000, 2'd1, 64'h0, 64'hDEF1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[6]  = mk(0, 1'b1, 40'h10_3000, 2'd2, 64'hAAAA_BBBB_CCCC_DDDD, 64'h0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[7]  = mk(0, 1'b0, 40'h10_3000, 2'd3, 64'h0, 64'hCCCC_DDDE, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tv[8]  = mk(0, 1'b1, 40'h10_2000, 2'd3, 64'h0, 64'h0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tv[9]  = mk(0, 1'b0, 40'h10_2000, 2'd3, 64'h0, 64'h1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tv[10] = mk(0, 1'b1, 40'h10_2000, 2'd3, 64'h1, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tv[11] = mk(0, 1'b0, 40'h10_2000, 2'd0, 64'h0, 64'h3, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tv[12] = mk(0, 1'b0, 40'h10_1000, 2'd3, 64'h0, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    tv[13] = mk(0, 1'b0, 40'h10_4000, 2'd3, 64'h0, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tv[14] = mk(0, 1'b1, 40'h10_2008, 2'd3, 64'h0, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tv[15] = mk(0, 1'b1, 40'h10_1000, 2'd0, 64'h1FF, 64'h0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1);
    tv[16] = mk(0, 1'b1, 40'h10_3000, 2'd0, 64'h3FE, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    tv[17] = mk(0, 1'b0, 40'h10_3000, 2'd1, 64'h0, 64'hFF, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(cmd_ready), 64'd0);
    chk("rst_resp_v", 64'(resp_v), 64'd0);
    chk("rst_char_v", 64'(char_v), 64'd0);
    chk("rst_flags", 64'({fin, fail, derr}), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_addr", 64'(resp_addr), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(cmd_ready), 64'd1);
    for (int k = 0; k < 18; k++) do_cmd(tv[k], k);
    cmd_v = 1'b1; cmd_w = 1'b1; cmd_addr = 40'h10_1000; cmd_size = 2'd0; cmd_data = 64'h42;
    @(posedge clk);
    @(negedge clk);
    cmd_addr = 40'h10_2000; cmd_data = 64'h0;
    nchar = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0) chk("hold_char", 64'(char_c), 64'h42);
      nchar += int'(char_v);
      chk($sformatf("hold_v[%0d]", i), 64'(resp_v), 64'd1);
      chk($sformatf("hold_ready[%0d]", i), 64'(cmd_ready), 64'd0);
      chk($sformatf("hold_fields[%0d]", i), {resp_data[21:0], resp_w, resp_addr, resp_size}, {22'd0, 1'b1, 40'h10_1000, 2'd0});
      @(negedge clk);
    end
    cmd_v = 1'b0;
    yumi = 1'b1;
    @(posedge clk);
    @(negedge clk);
    yumi = 1'b0;
    chk("hold_char_count", 64'(nchar), 64'd1);
    chk("after_yumi_ready", 64'(cmd_ready), 64'd1);
    chk("after_yumi_resp_v", 64'(resp_v), 64'd0);
    chk("ignored_cmd_fail", 64'(fail), 64'd1);
    cmd_v = 1'b1; cmd_w = 1'b0; cmd_addr = 40'h10_3000; cmd_size = 2'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_v = 1'b0;
    chk("mid_resp_v", 64'(resp_v), 64'd1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_resp_v", 64'(resp_v), 64'd0);
    chk("mid_rst_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_flags", 64'({fin, fail, derr}), 64'd0);
    chk("mid_rst_resp_data", resp_data, 64'd0);
    chk("mid_rst_resp_addr", 64'(resp_addr), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("mid_rst_release_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("no_ghost[%0d]", i), 64'(resp_v), 64'd0);
    end
    do_cmd(mk(0, 1'b0, 40'h10_3000, 2'd3, 64'h0, 64'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0), 100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
